// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity encodings and baud divisor helper
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input longint clk_freq, input longint baud,
                                    input longint oversample);
        longint den;
        den = baud * oversample;
        return int'((clk_freq + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divider emitting a 1-cycle tick every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 326
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with error detection and a one-deep output register
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BIW = $clog2(DATA_BITS);

    localparam logic [SCW-1:0] SC_LO   = SCW'(M - 1);
    localparam logic [SCW-1:0] SC_MID  = SCW'(M);
    localparam logic [SCW-1:0] SC_HI   = SCW'(M + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

    rx_state_t            state, state_n;
    logic                 tick;
    logic                 rxd_meta, rxd_s;
    logic                 armed;
    logic [SCW-1:0]       sc;
    logic [BIW-1:0]       bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 samp_lo, samp_mid;
    logic                 par_bit, stop1, stop_idx;
    logic                 maj, at_mid, at_wrap, complete;
    logic                 stop_first, par_exp, fe_new, pe_new, brk_new;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst),
        .tick  (tick)
    );

    // Third vote is the live synchronised sample taken at sc = M+1.
    assign maj     = (samp_lo & samp_mid) | (samp_lo & rxd_s) | (samp_mid & rxd_s);
    assign at_mid  = tick && (sc == SC_HI);
    assign at_wrap = tick && (sc == SC_LAST);

    assign stop_first = stop_idx ? stop1 : maj;
    assign par_exp    = (^shreg) ^ (PARITY == PAR_ODD);
    assign fe_new     = ~stop_first;
    assign pe_new     = (PARITY != PAR_NONE) && (par_bit != par_exp);
    assign brk_new    = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && !stop_first;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        complete = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick && armed && !rxd_s) state_n = S_START;
            end
            S_START: begin
                if (at_mid && maj) state_n = S_IDLE;
                else if (at_wrap)  state_n = S_DATA;
            end
            S_DATA: begin
                if (at_wrap && (bit_idx == BIW'(DATA_BITS - 1)))
                    state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (at_wrap) state_n = S_STOP;
            end
            S_STOP: begin
                // Leave at mid-bit of the last stop so a back-to-back start edge is seen.
                if (at_mid && (stop_idx == 1'(STOP_BITS - 1))) begin
                    state_n  = S_IDLE;
                    complete = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            armed    <= 1'b0;
            sc       <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            samp_lo  <= 1'b1;
            samp_mid <= 1'b1;
            par_bit  <= 1'b0;
            stop1    <= 1'b1;
            stop_idx <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            if (tick && rxd_s) armed <= 1'b1;
            if (state == S_IDLE) begin
                sc       <= '0;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
            end else if (tick) begin
                sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
                if (sc == SC_LO)  samp_lo  <= rxd_s;
                if (sc == SC_MID) samp_mid <= rxd_s;
            end
            if (state == S_DATA && at_mid)   shreg   <= {maj, shreg[DATA_BITS-1:1]};
            if (state == S_DATA && at_wrap)  bit_idx <= bit_idx + 1'b1;
            if (state == S_PARITY && at_mid) par_bit <= maj;
            if (state == S_STOP && at_mid && !stop_idx) stop1 <= maj;
            if (state == S_STOP && at_wrap)  stop_idx <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_done   <= complete;
            break_det <= complete && brk_new;
            overrun   <= 1'b0;
            if (complete && (!rx_valid || rx_ready)) begin
                rx_data    <= shreg;
                frame_err  <= fe_new;
                parity_err <= pe_new;
                rx_valid   <= 1'b1;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for 8N1 and 8E2 receiver instances
module tb_uart_rx_param;

    localparam int CLK_NS = 20;
    localparam int BIT_NS = 1280;   // 64 MHz / (1 Mbaud * 16) -> 4 clocks per tick, 64 per bit

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd_a = 1'b1, rxd_b = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic valid_a, done_a, fe_a, pe_a, brk_a, ovr_a;
    logic valid_b, done_b, fe_b, pe_b, brk_b, ovr_b;

    int cmp_count = 0;
    int err_count = 0;
    int exp_done [2];
    int exp_brk  [2];
    int exp_ovr  [2];
    int act_done_a = 0, act_brk_a = 0, act_ovr_a = 0;
    int act_done_b = 0, act_brk_b = 0, act_ovr_b = 0;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    always #(CLK_NS / 2) clk = ~clk;

    uart_rx_param #(.CLK_FREQ(64_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .rx_done(done_a), .frame_err(fe_a), .parity_err(pe_a),
        .break_det(brk_a), .overrun(ovr_a)
    );

    uart_rx_param #(.CLK_FREQ(64_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .rx_done(done_b), .frame_err(fe_b), .parity_err(pe_b),
        .break_det(brk_b), .overrun(ovr_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected {parity_err, frame_err, data}; instance b uses even parity.
    function automatic logic [9:0] model_word(input int which, input logic [7:0] d,
                                              input logic pbit, input logic stop1);
        logic fe, pe;
        fe = (stop1 == 1'b0);
        pe = (which == 1) && (pbit != logic'($countones(d) % 2));
        return {pe, fe, d};
    endfunction

    function automatic bit model_break(input int which, input logic [7:0] d,
                                       input logic pbit, input logic stop1);
        return (d == 8'h00) && (which == 0 || pbit == 1'b0) && (stop1 == 1'b0);
    endfunction

    task automatic push(input int which, input logic [9:0] w);
        if (which == 0) q_a.push_back(w);
        else            q_b.push_back(w);
    endtask

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rxd_a = v;
        else            rxd_b = v;
        #(BIT_NS);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                              input logic stop1, input int idle_bits, input bit deliver);
        exp_done[which]++;
        if (model_break(which, d, pbit, stop1)) exp_brk[which]++;
        if (deliver) push(which, model_word(which, d, pbit, stop1));
        else         exp_ovr[which]++;
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (which == 1) drive_bit(which, pbit);
        drive_bit(which, stop1);
        if (which == 1) drive_bit(which, 1'b1);
        repeat (idle_bits) drive_bit(which, 1'b1);
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_a_done"},    act_done_a, exp_done[0]);
        check({tag, "_a_break"},   act_brk_a,  exp_brk[0]);
        check({tag, "_a_overrun"}, act_ovr_a,  exp_ovr[0]);
        check({tag, "_a_pending"}, q_a.size(), 0);
        check({tag, "_b_done"},    act_done_b, exp_done[1]);
        check({tag, "_b_break"},   act_brk_b,  exp_brk[1]);
        check({tag, "_b_overrun"}, act_ovr_b,  exp_ovr[1]);
        check({tag, "_b_pending"}, q_b.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            act_done_a += int'(done_a);
            act_brk_a  += int'(brk_a);
            act_ovr_a  += int'(ovr_a);
            act_done_b += int'(done_b);
            act_brk_b  += int'(brk_b);
            act_ovr_b  += int'(ovr_b);
            if (valid_a && ready_a) begin
                check("a_word_expected", 32'(q_a.size() > 0), 1);
                if (q_a.size() > 0) check("a_word", {22'd0, pe_a, fe_a, data_a}, {22'd0, q_a.pop_front()});
            end
            if (valid_b && ready_b) begin
                check("b_word_expected", 32'(q_b.size() > 0), 1);
                if (q_b.size() > 0) check("b_word", {22'd0, pe_b, fe_b, data_b}, {22'd0, q_b.pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] a5;
        logic [7:0] d;
        logic       pbit, stop1;
        int         idle;

        for (int i = 0; i < 2; i++) begin
            exp_done[i] = 0;
            exp_brk[i]  = 0;
            exp_ovr[i]  = 0;
        end

        #(5 * CLK_NS);
        check("a_reset_outputs", {17'd0, data_a, valid_a, done_a, fe_a, pe_a, brk_a, ovr_a}, 0);
        check("b_reset_outputs", {17'd0, data_b, valid_b, done_b, fe_b, pe_b, brk_b, ovr_b}, 0);
        rst = 1'b1;
        #(4 * BIT_NS);

        send_frame(0, 8'h41, 1'b0, 1'b1, 2, 1'b1);
        checkpoint("basic_8n1");

        send_frame(1, 8'h41, 1'b0, 1'b1, 1, 1'b1);
        send_frame(1, 8'h41, 1'b1, 1'b1, 2, 1'b1);
        checkpoint("parity_even");

        send_frame(0, 8'h55, 1'b0, 1'b0, 2, 1'b1);
        send_frame(0, 8'h00, 1'b0, 1'b0, 2, 1'b1);
        checkpoint("framing_break");

        rxd_a = 1'b0;
        #(18 * CLK_NS);
        rxd_a = 1'b1;
        #(3 * BIT_NS);
        checkpoint("glitch");
        send_frame(0, 8'h41, 1'b0, 1'b1, 2, 1'b1);
        checkpoint("after_glitch");

        @(posedge clk); #1 ready_a = 1'b0;
        send_frame(0, 8'h41, 1'b0, 1'b1, 0, 1'b1);
        send_frame(0, 8'h42, 1'b0, 1'b1, 1, 1'b0);
        check("overrun_held_data", {24'd0, data_a}, 32'h41);
        @(posedge clk); #1 ready_a = 1'b1;
        @(posedge clk); #1 ready_a = 1'b0;
        @(negedge clk);
        check("overrun_valid_drop", {31'd0, valid_a}, 0);
        @(posedge clk); #1 ready_a = 1'b1;
        checkpoint("overrun");

        // The aborted 0xA5 leaves bits 5..7 on the line; the receiver re-arms on
        // bit 5 and decodes the falling edge of bit 6 as a fresh all-ones frame.
        a5 = 8'hA5;
        exp_done[0]++;
        push(0, {2'b00, 8'hFF});
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, a5[i]);
        rxd_a = a5[3];
        #(BIT_NS / 2);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        rst = 1'b1;
        #(BIT_NS / 2 - 5 * CLK_NS);
        for (int i = 4; i < 8; i++) drive_bit(0, a5[i]);
        drive_bit(0, 1'b1);
        repeat (10) drive_bit(0, 1'b1);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 2, 1'b1);
        checkpoint("reset_abort");

        for (int w = 0; w < 2; w++) begin
            for (int n = 0; n < 16; n++) begin
                d = 8'($urandom);
                if ($urandom_range(0, 7) == 0) d = 8'h00;
                stop1 = ($urandom_range(0, 5) != 0);
                pbit  = (w == 1) ? (logic'($countones(d) % 2) ^ ($urandom_range(0, 3) == 0)) : 1'b0;
                idle  = stop1 ? int'($urandom_range(0, 2)) : 2;
                send_frame(w, d, pbit, stop1, idle, 1'b1);
            end
            #(2 * BIT_NS);
        end
        checkpoint("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 UART receiver: configurable clock/baud, data width, parity and stop bits. Adds 16x oversampling with 3-sample majority vote, false-start rejection, and framing/parity/break/overrun detection. Received words leave through a one-deep valid/ready holding register. It sits between the board serial pin and the sensor command/telemetry parser on the 50 MHz domain.

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz
BAUD, 9600, line rate in bits/s
OVERSAMPLE, 16, ticks per bit; must be even and >= 8
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
rxd  input  1  serial line, idle high, LSB first, asynchronous to clk
rx_data  output  DATA_BITS  received word, stable while rx_valid = 1
rx_valid  output  1  rx_data, frame_err and parity_err hold a word
rx_ready  input  1  consumer accepts the word on a cycle where rx_valid && rx_ready
rx_done  output  1  1-cycle pulse on every completed frame, accepted or dropped
frame_err  output  1  first stop bit sampled 0; qualified by rx_valid
parity_err  output  1  parity mismatch; always 0 when PARITY = 0; qualified by rx_valid
break_det  output  1  1-cycle pulse: all data bits 0, parity bit 0 if present, stop bit 0
overrun  output  1  1-cycle pulse: frame completed while the holding register was full and not being read

Behaviour:
- Reset (rst = 0, asynchronous):
  - All outputs 0; rx_data = 0; FSM = IDLE.
  - Synchronizer flops reset to 1; armed flag cleared.
- Reset mid-frame aborts the frame. No rx_done or error is reported for it.
- Input synchronisation: 2-flop synchronizer on rxd. All logic uses the synchronised value.
- Tick generation:
  - DIV = round(CLK_FREQ / (BAUD * OVERSAMPLE)); default = 326.
  - tick is a 1-cycle pulse every DIV clocks, free-running from reset.
- armed: set when the synchronised rxd is 1 on any tick; cleared at reset. A line held low through reset cannot start a frame.
- Sample counter sc runs 0..OVERSAMPLE-1 per bit.
  - The bit value is the majority of samples at sc = M-1, M, M+1, where M = OVERSAMPLE/2.
- FSM:
  - IDLE -> START when armed and synchronised rxd = 0 on a tick; sc = 0.
  - START: at sc = M+1, majority 1 -> IDLE (false start, no pulse); majority 0 -> continue. At sc wrap -> DATA.
  - DATA: shift in LSB first; bit index 0..DATA_BITS-1. After the last bit wraps -> PARITY if PARITY != 0, else STOP.
  - PARITY: compare the sampled bit with the expected value. Odd: XOR(data) ^ 1. Even: XOR(data).
  - STOP: sampled at sc = M+1.
    - If this is the final stop bit, complete the frame immediately and go to IDLE without waiting for the bit end, so a back-to-back start is caught.
    - With STOP_BITS = 2: frame_err uses only the first stop bit; the second bit is skipped without check, sampled at its midpoint.
- Frame completion, evaluated in the cycle after the final stop mid-sample:
  - rx_done pulses.
  - break_det pulses if the break condition holds. The word is still delivered, with frame_err = 1.
  - If rx_valid = 0, or rx_valid && rx_ready in this same cycle: load rx_data, frame_err and parity_err; rx_valid = 1.
  - Otherwise: overrun pulses; the new word is dropped and the old word and flags are kept.
- Handshake: rx_valid falls on the cycle after acceptance unless a new word loads in that same cycle.
- Latency: rx_valid rises 1 clock after the final stop mid-sample tick. At default settings that is about 9.5 bit times from the start edge (~989 us).

Decomposition:
- Package uart_pkg:
  - rx state typedef (IDLE, START, DATA, PARITY, STOP).
  - parity encoding constants (PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2).
  - function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE.
- Sub-module uart_baud_tick: parametrised divider producing tick. It is reused later by the transmitter.

Test Plan:
- Default 8N1, send 0x41 at BIT_PERIOD 104_160 ns, rx_ready = 1 -> rx_valid pulse with rx_data = 0x41; rx_done = 1 once; all error flags 0.
- PARITY = 2, send 0x41 with parity 0 -> parity_err = 0; repeat with parity 1 -> rx_data = 0x41, parity_err = 1.
- Send 0x55 with stop bit 0 -> frame_err = 1; send 0x00 with stop bit 0 -> frame_err = 1 and break_det pulses once.
- rxd low glitch of 30 us (~4.6 ticks), then idle -> no rx_done and no rx_valid; a following 0x41 is received correctly.
- rx_ready = 0, send 0x41 then 0x42 back to back -> rx_data stays 0x41, overrun pulses once at the second rx_done. Then rx_ready = 1 for one cycle -> rx_valid drops.
- Assert rst for 5 clocks during data bit 3 of 0xA5 while rxd continues the frame -> no output for that frame; the next 0x3C sent after idle is received correctly.
